// File: rtl/id_exe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : id_exe_stage_reg_pkg
//  Brief    : Shared types for the ID/EXE elastic stage register:
//             ALU command encodings, the stage payload record, the
//             buffer-occupancy state enum and a small payload helper.
//  Revision : 1.0 - initial release
// ============================================================================
package id_exe_stage_reg_pkg;

  // Payload field widths; the payload record below is sized from these.
  localparam int P_DATA_W = 32;
  localparam int P_REG_AW = 4;

  // ALU command encodings carried in exe_cmd.
  localparam logic [3:0] c_EXE_MOV = 4'b0001;
  localparam logic [3:0] c_EXE_MVN = 4'b1001;
  localparam logic [3:0] c_EXE_ADD = 4'b0010;
  localparam logic [3:0] c_EXE_ADC = 4'b0011;
  localparam logic [3:0] c_EXE_SUB = 4'b0100;
  localparam logic [3:0] c_EXE_SBC = 4'b0101;
  localparam logic [3:0] c_EXE_AND = 4'b0110;
  localparam logic [3:0] c_EXE_ORR = 4'b0111;
  localparam logic [3:0] c_EXE_EOR = 4'b1000;
  // Compare/test reuse the subtract/and paths; loads and stores use add
  // for address generation.
  localparam logic [3:0] c_EXE_CMP = 4'b0100;
  localparam logic [3:0] c_EXE_TST = 4'b0110;
  localparam logic [3:0] c_EXE_LDR = 4'b0010;
  localparam logic [3:0] c_EXE_STR = 4'b0010;

  // Buffer occupancy: nothing held, main slot only, main and skid slots.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  // Everything decode hands to execute for one instruction.
  typedef struct packed {
    logic [P_DATA_W-1:0] pc;
    logic                wb_en;
    logic                mem_r_en;
    logic                mem_w_en;
    logic                b;
    logic                s;
    logic                i;
    logic [3:0]          exe_cmd;
    logic [P_REG_AW-1:0] dest;
    logic [P_REG_AW-1:0] src1;
    logic [P_REG_AW-1:0] src2;
    logic [P_DATA_W-1:0] val_rn;
    logic [P_DATA_W-1:0] val_rm;
    logic [11:0]         shifter_operand;
    logic [23:0]         signed_imm_24;
    logic                carry;
  } id_exe_payload_t;

  // The Val2 generator treats any memory access as an address computation.
  function automatic logic f_for_mem(input id_exe_payload_t p);
    return p.mem_r_en | p.mem_w_en;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_exe_stage_reg_payload_slot.sv
`default_nettype none
// ============================================================================
//  Module   : id_exe_stage_reg_payload_slot
//  Brief    : One payload storage slot of the ID/EXE buffer. Loads when
//             enabled and otherwise holds, so unused data never toggles.
//             Cleared asynchronously by the active-low reset.
//  Revision : 1.0 - initial release
// ============================================================================
module id_exe_stage_reg_payload_slot
  import id_exe_stage_reg_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  id_exe_payload_t i_d,
  output id_exe_payload_t o_q
);

  id_exe_payload_t r_q;

  // Capture a new payload on load, otherwise hold the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : id_exe_stage_reg
//  Brief    : Elastic ID->EXE pipeline register. Two-entry skid buffer
//             (main + skid slot) with valid/ready on both sides, a
//             registered ID-side ready and a flush for taken branches.
//             Control outputs are forced low during bubbles.
//  Revision : 1.0 - initial release
// ============================================================================
module id_exe_stage_reg
  import id_exe_stage_reg_pkg::*;
#(
  // The payload record is sized by the package constants; keep these equal.
  parameter int DATA_W = P_DATA_W,
  parameter int REG_AW = P_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  // ID side handshake
  input  logic              i_id_valid,
  output logic              o_id_ready,
  // EXE side handshake
  output logic              o_exe_valid,
  input  logic              i_exe_ready,
  // Decoded fields from ID
  input  logic [DATA_W-1:0] i_pc,
  input  logic              i_wb_en,
  input  logic              i_mem_r_en,
  input  logic              i_mem_w_en,
  input  logic              i_b,
  input  logic              i_s,
  input  logic              i_i,
  input  logic [3:0]        i_exe_cmd,
  input  logic [REG_AW-1:0] i_dest,
  input  logic [REG_AW-1:0] i_src1,
  input  logic [REG_AW-1:0] i_src2,
  input  logic [DATA_W-1:0] i_val_rn,
  input  logic [DATA_W-1:0] i_val_rm,
  input  logic [11:0]       i_shifter_operand,
  input  logic [23:0]       i_signed_imm_24,
  input  logic              i_carry,
  // Registered fields to EXE
  output logic [DATA_W-1:0] o_pc,
  output logic              o_wb_en,
  output logic              o_mem_r_en,
  output logic              o_mem_w_en,
  output logic              o_b,
  output logic              o_s,
  output logic              o_i,
  output logic [3:0]        o_exe_cmd,
  output logic [REG_AW-1:0] o_dest,
  output logic [REG_AW-1:0] o_src1,
  output logic [REG_AW-1:0] o_src2,
  output logic [DATA_W-1:0] o_val_rn,
  output logic [DATA_W-1:0] o_val_rm,
  output logic [11:0]       o_shifter_operand,
  output logic [23:0]       o_signed_imm_24,
  output logic              o_carry,
  output logic              o_for_mem
);

  stage_state_t    r_state;
  stage_state_t    w_state_nxt;
  logic            r_id_ready;

  logic            w_exe_valid;
  logic            w_accept;
  logic            w_consume;
  logic            w_main_load;
  logic            w_main_from_skid;
  logic            w_skid_load;

  id_exe_payload_t w_in;
  id_exe_payload_t w_main_d;
  id_exe_payload_t w_main_q;
  id_exe_payload_t w_skid_q;

  assign w_in = '{
    pc:              i_pc,
    wb_en:           i_wb_en,
    mem_r_en:        i_mem_r_en,
    mem_w_en:        i_mem_w_en,
    b:               i_b,
    s:               i_s,
    i:               i_i,
    exe_cmd:         i_exe_cmd,
    dest:            i_dest,
    src1:            i_src1,
    src2:            i_src2,
    val_rn:          i_val_rn,
    val_rm:          i_val_rm,
    shifter_operand: i_shifter_operand,
    signed_imm_24:   i_signed_imm_24,
    carry:           i_carry
  };

  // The main slot is what EXE sees; it is valid whenever anything is held.
  assign w_exe_valid = (r_state != ST_EMPTY);
  // Ready comes straight from a flop, so accept never depends on exe_ready.
  assign w_accept    = i_id_valid & r_id_ready;
  assign w_consume   = w_exe_valid & i_exe_ready;

  // Next occupancy and which slot captures what; flush overrides everything
  // and leaves the slot contents untouched so data outputs do not toggle.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_load = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_consume) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load = 1'b1;
            w_state_nxt = ST_TWO;
          end else if (w_consume) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Ready is low here, so only the drain of main into EXE matters.
          if (w_consume) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Occupancy register plus ready precomputed from the next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_id_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_id_ready <= (w_state_nxt != ST_TWO);
    end
  end

  // The skid entry is always older than anything arriving from ID.
  assign w_main_d = w_main_from_skid ? w_skid_q : w_in;

  id_exe_stage_reg_payload_slot u_main_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  id_exe_stage_reg_payload_slot u_skid_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_skid_load),
    .i_d    (w_in),
    .o_q    (w_skid_q)
  );

  assign o_id_ready  = r_id_ready;
  assign o_exe_valid = w_exe_valid;

  // Side-effecting controls are gated so a bubble can never write or branch.
  assign o_wb_en     = w_exe_valid & w_main_q.wb_en;
  assign o_mem_r_en  = w_exe_valid & w_main_q.mem_r_en;
  assign o_mem_w_en  = w_exe_valid & w_main_q.mem_w_en;
  assign o_b         = w_exe_valid & w_main_q.b;
  assign o_s         = w_exe_valid & w_main_q.s;
  assign o_for_mem   = w_exe_valid & f_for_mem(w_main_q);

  // Data fields pass through unchanged and simply hold during bubbles.
  assign o_pc              = w_main_q.pc;
  assign o_i               = w_main_q.i;
  assign o_exe_cmd         = w_main_q.exe_cmd;
  assign o_dest            = w_main_q.dest;
  assign o_src1            = w_main_q.src1;
  assign o_src2            = w_main_q.src2;
  assign o_val_rn          = w_main_q.val_rn;
  assign o_val_rm          = w_main_q.val_rm;
  assign o_shifter_operand = w_main_q.shifter_operand;
  assign o_signed_imm_24   = w_main_q.signed_imm_24;
  assign o_carry           = w_main_q.carry;

endmodule
`default_nettype wire

// File: tb/tb_id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_exe_stage_reg
//  Brief    : Self-checking bench for id_exe_stage_reg: queue scoreboard of
//             accepted payloads, a per-cycle vector table and hand-written
//             reset / Val2 / mid-operation reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_exe_stage_reg;
  import id_exe_stage_reg_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  logic id_valid;
  logic exe_ready;
  id_exe_payload_t drv;

  logic        o_id_ready, o_exe_valid, o_for_mem;
  logic [31:0] o_pc, o_val_rn, o_val_rm;
  logic        o_wb_en, o_mem_r_en, o_mem_w_en, o_b, o_s, o_i, o_carry;
  logic [3:0]  o_exe_cmd, o_dest, o_src1, o_src2;
  logic [11:0] o_shifter_operand;
  logic [23:0] o_signed_imm_24;
  id_exe_payload_t got;

  int n_assert = 0;
  int n_fail   = 0;
  id_exe_payload_t sb[$];
  bit exp_ready;

  typedef struct {
    bit          idv;
    logic [31:0] pc;
    bit          er;
    bit          fl;
    bit          ev;
    bit          rdy;
    logic [31:0] epc;
  } vec_t;
  vec_t vecs[13];

  id_exe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush),
    .i_id_valid(id_valid), .o_id_ready(o_id_ready),
    .o_exe_valid(o_exe_valid), .i_exe_ready(exe_ready),
    .i_pc(drv.pc), .i_wb_en(drv.wb_en), .i_mem_r_en(drv.mem_r_en),
    .i_mem_w_en(drv.mem_w_en), .i_b(drv.b), .i_s(drv.s), .i_i(drv.i),
    .i_exe_cmd(drv.exe_cmd), .i_dest(drv.dest), .i_src1(drv.src1),
    .i_src2(drv.src2), .i_val_rn(drv.val_rn), .i_val_rm(drv.val_rm),
    .i_shifter_operand(drv.shifter_operand),
    .i_signed_imm_24(drv.signed_imm_24), .i_carry(drv.carry),
    .o_pc(o_pc), .o_wb_en(o_wb_en), .o_mem_r_en(o_mem_r_en),
    .o_mem_w_en(o_mem_w_en), .o_b(o_b), .o_s(o_s), .o_i(o_i),
    .o_exe_cmd(o_exe_cmd), .o_dest(o_dest), .o_src1(o_src1),
    .o_src2(o_src2), .o_val_rn(o_val_rn), .o_val_rm(o_val_rm),
    .o_shifter_operand(o_shifter_operand),
    .o_signed_imm_24(o_signed_imm_24), .o_carry(o_carry),
    .o_for_mem(o_for_mem)
  );

  assign got = '{
    pc: o_pc, wb_en: o_wb_en, mem_r_en: o_mem_r_en, mem_w_en: o_mem_w_en,
    b: o_b, s: o_s, i: o_i, exe_cmd: o_exe_cmd, dest: o_dest, src1: o_src1,
    src2: o_src2, val_rn: o_val_rn, val_rm: o_val_rm,
    shifter_operand: o_shifter_operand, signed_imm_24: o_signed_imm_24,
    carry: o_carry
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkp(input string name, input id_exe_payload_t act, input id_exe_payload_t exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc=%0h payload=%0h expected pc=%0h payload=%0h (t=%0t)",
               name, act.pc, act, exp.pc, exp, $time);
    end
  endtask

  // Control bits follow pc[2]/pc[3] so some held entries have every
  // gated control set; data fields are random.
  function automatic id_exe_payload_t mk(input logic [31:0] pc);
    id_exe_payload_t p;
    p.pc              = pc;
    p.wb_en           = pc[2];
    p.mem_r_en        = pc[2];
    p.mem_w_en        = pc[3];
    p.b               = pc[2];
    p.s               = pc[2];
    p.i               = pc[4];
    p.exe_cmd         = 4'($urandom);
    p.dest            = 4'($urandom);
    p.src1            = 4'($urandom);
    p.src2            = 4'($urandom);
    p.val_rn          = $urandom;
    p.val_rm          = $urandom;
    p.shifter_operand = 12'($urandom);
    p.signed_imm_24   = 24'($urandom);
    p.carry           = 1'($urandom);
    return p;
  endfunction

  task automatic drive(input bit idv, input logic [31:0] pc, input bit er, input bit fl);
    id_valid  = idv;
    drv       = mk(pc);
    exe_ready = er;
    flush     = fl;
  endtask

  // One clock: check the presented entry against the scoreboard at the
  // falling edge, update the scoreboard from the handshakes, step the edge.
  task automatic cycle();
    bit acc, con;
    @(negedge clk);
    chk("exe_valid", 32'(o_exe_valid), 32'(sb.size() != 0));
    chk("id_ready", 32'(o_id_ready), 32'(exp_ready));
    if (sb.size() != 0) begin
      chkp("payload", got, sb[0]);
      chk("for_mem", 32'(o_for_mem), 32'(sb[0].mem_r_en | sb[0].mem_w_en));
    end else begin
      chk("bubble ctrl", 32'({o_wb_en, o_mem_r_en, o_mem_w_en, o_b, o_s, o_for_mem}), 32'd0);
    end
    acc = id_valid & o_id_ready;
    con = o_exe_valid & exe_ready;
    if (con && sb.size() != 0) void'(sb.pop_front());
    if (flush) sb.delete();
    else if (acc) sb.push_back(drv);
    exp_ready = (sb.size() < 2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // idv, pc, er, fl  ->  exe_valid, id_ready, pc after the edge
    vecs[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10};
    vecs[1]  = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10};
    vecs[2]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10};
    vecs[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h14};
    vecs[4]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h14};
    vecs[5]  = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20};
    vecs[6]  = '{1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20};
    vecs[7]  = '{1'b1, 32'h18, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20};
    vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20};
    vecs[9]  = '{1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 1'b1, 32'h30};
    vecs[10] = '{1'b1, 32'h34, 1'b1, 1'b1, 1'b0, 1'b1, 32'h30};
    vecs[11] = '{1'b1, 32'h38, 1'b1, 1'b0, 1'b1, 1'b1, 32'h38};
    vecs[12] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h38};

    // Reset with live random inputs: everything must sit at reset values.
    rst_n     = 1'b0;
    id_valid  = 1'b1;
    exe_ready = 1'($urandom);
    flush     = 1'b0;
    drv       = mk(32'hdead_beec);
    repeat (2) @(posedge clk);
    #1;
    chk("reset exe_valid", 32'(o_exe_valid), 32'd0);
    chk("reset id_ready", 32'(o_id_ready), 32'd1);
    chkp("reset outputs", got, '0);
    chk("reset for_mem", 32'(o_for_mem), 32'd0);
    id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    exp_ready = 1'b1;

    // First accept: visible one cycle later.
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    cycle();
    chk("first exe_valid", 32'(o_exe_valid), 32'd1);
    chk("first pc", o_pc, 32'h4);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cycle();

    // Streaming at full rate: each pc appears exactly one cycle later.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 32'(4 * k), 1'b1, 1'b0);
      cycle();
      chk("stream pc", o_pc, 32'(4 * k));
      chk("stream id_ready", 32'(o_id_ready), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("stream drained", 32'(o_exe_valid), 32'd0);

    // Backpressure and flush vectors.
    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].idv, vecs[v].pc, vecs[v].er, vecs[v].fl);
      cycle();
      chk($sformatf("vec%0d exe_valid", v), 32'(o_exe_valid), 32'(vecs[v].ev));
      chk($sformatf("vec%0d id_ready", v), 32'(o_id_ready), 32'(vecs[v].rdy));
      chk($sformatf("vec%0d pc", v), o_pc, vecs[v].epc);
    end

    // Val2 feed held under backpressure.
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    drv.mem_r_en        = 1'b1;
    drv.mem_w_en        = 1'b0;
    drv.i               = 1'b0;
    drv.shifter_operand = 12'h0FF;
    drv.val_rm          = 32'h1234;
    cycle();
    id_valid = 1'b0;
    for (int h = 0; h < 3; h++) begin
      cycle();
      chk("val2 for_mem", 32'(o_for_mem), 32'd1);
      chk("val2 shifter", 32'(o_shifter_operand), 32'h0FF);
      chk("val2 val_rm", o_val_rm, 32'h1234);
    end
    exe_ready = 1'b1;
    cycle();
    cycle();

    // Reset between edges while two entries are held.
    drive(1'b1, 32'h54, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h5c, 1'b0, 1'b0);
    cycle();
    chk("pre-reset id_ready", 32'(o_id_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset exe_valid", 32'(o_exe_valid), 32'd0);
    chk("async reset id_ready", 32'(o_id_ready), 32'd1);
    chkp("async reset outputs", got, '0);
    chk("async reset for_mem", 32'(o_for_mem), 32'd0);
    sb.delete();
    exp_ready = 1'b1;
    id_valid  = 1'b0;
    exe_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();
    chk("post-reset pc", o_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- Elastic pipeline register between the decode (ID) stage and the execute (EXE) stage.
- Captures decoded control and operands from ID and presents them registered to EXE. Consumers are the Val2 generator (I, for_mem, shifter_operand, Val_Rm), the ALU and the branch adder.
- Two-entry skid buffer with valid/ready handshakes on both sides and a flush input for taken branches.
- Full throughput, with ID-side ready driven from a register.

Parameters:
- DATA_W, 32, operand/PC width.
- REG_AW, 4, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  branch taken in EXE; kill all held and incoming entries.
- id_valid  in  1  ID presents an instruction.
- id_ready  out  1  buffer can accept; registered.
- exe_valid  out  1  EXE-side entry valid.
- exe_ready  in  1  EXE consumes the entry this cycle.
- in_pc  in  DATA_W  PC+4 of the instruction.
- in_wb_en, in_mem_r_en, in_mem_w_en, in_B, in_S, in_I  in  1 each  decoded control bits.
- in_exe_cmd  in  4  ALU command.
- in_dest, in_src1, in_src2  in  REG_AW  register addresses.
- in_Val_Rn, in_Val_Rm  in  DATA_W  register-file read data.
- in_shifter_operand  in  12  shifter operand field.
- in_signed_imm_24  in  24  branch offset.
- in_carry  in  1  status-register C at decode.
- out_*  out  same widths  registered copies of every in_* field.
- for_mem  out  1  out_mem_r_en | out_mem_w_en; drives the Val2 generator.

Behaviour:
- Reset (rst=0, async): state EMPTY, exe_valid=0, id_ready=1, all out_* and for_mem=0.
- Handshakes:
  - accept = id_valid & id_ready.
  - consume = exe_valid & exe_ready.
  - Payload is held stable while exe_valid & !exe_ready.
- States: EMPTY (0 entries), ONE (main slot valid), TWO (main and skid slots valid).
- EMPTY:
  - accept -> main<=in; go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - accept & consume -> main<=in; stay in ONE.
  - accept & !consume -> skid<=in; go to TWO.
  - !accept & consume -> go to EMPTY.
  - Otherwise hold.
- TWO:
  - id_ready=0, so there is no accept.
  - consume -> main<=skid; go to ONE.
  - Otherwise hold.
- Register updates: id_ready is registered and equals (next_state != TWO). exe_valid = (state != EMPTY).
- Latency: 1 cycle from accept to exe_valid when the buffer is EMPTY. Steady throughput is 1 instruction per cycle with exe_ready held high.
- Ordering: strict FIFO order; no entry is lost or duplicated.
- Flush:
  - Highest priority. The next state is EMPTY regardless of accept or consume.
  - An instruction accepted in the flush cycle is discarded.
  - id_ready=1 the following cycle.
- Bubble safety: when exe_valid=0, out_wb_en, out_mem_r_en, out_mem_w_en, out_B, out_S and for_mem are forced to 0.
  - Data fields are don't-care but must hold their last value; no toggling is permitted.
- No arithmetic is performed; fields pass bit-exact. for_mem is derived from registered bits only, never from the in_* inputs.
- Reset asserted mid-operation: immediate return to the reset values. In-flight entries are lost and no handshake is completed.

Decomposition:
- Shared package (pipeline pkg):
  - exe_cmd encodings (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, CMP/TST/LDR/STR).
  - Stage payload struct holding all in_* fields.
  - State enum EMPTY/ONE/TWO.
- One natural sub-module: payload_slot, an enable-loaded payload register with async active-low clear. It is instantiated twice, as main and skid.
- The FSM and muxing stay in id_exe_stage_reg.

Test Plan:
- Reset: rst=0 with random inputs -> exe_valid=0, id_ready=1, out_* = 0, for_mem=0. After rst=1 and one accept of in_pc=0x0000_0004, exe_valid=1 next cycle with out_pc=0x4.
- Streaming: id_valid=1 and exe_ready=1 for 8 cycles with pc=4,8,...,32 -> out_pc sequence identical, delayed 1 cycle, one per cycle, and id_ready stays 1.
- Backpressure: exe_ready=0 while 2 instructions are accepted (pc=0x10, 0x14) -> id_ready=0 the cycle after the 2nd accept. Raising exe_ready gives 0x10 then 0x14, with no loss.
- Flush in TWO with id_valid=1 (pc=0x18) -> next cycle exe_valid=0, for_mem=0, id_ready=1; pc 0x18 never appears on the outputs.
- Val2 feed: accept mem_r_en=1, I=0, shifter_operand=0x0FF, Val_Rm=0x1234 -> for_mem=1, out_shifter_operand=0x0FF, out_Val_Rm=0x1234 while the entry is held under exe_ready=0 for 3 cycles.
- Reset mid-operation: rst pulsed low while in TWO, between clock edges -> outputs clear asynchronously, before the next edge; neither held entry is emitted afterwards.
